// File: rtl/instruction_decode.sv
// ID stage of the classic 5-stage MIPS pipe: decode, 32x32 regfile with WB bypass,
// early branch resolve and hazard stall. Optional STALL_COUNT_EN adds a StallCount port.
module instruction_decode (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IFID_Instruction,
  input  logic [31:0] IFID_PCPlus4,
  input  logic        Prop_IFFlush,
  input  logic        WB_RegWrite,
  input  logic [4:0]  WB_WriteReg,
  input  logic [31:0] WB_WriteData,
  input  logic        EXMEM_RegWrite,
  input  logic        EXMEM_MemRead,
  input  logic [4:0]  EXMEM_WriteReg,
  output logic        Zero,
  output logic        Branch,
  output logic        BranchNe,
  output logic        IFFlush,
  output logic        Stall,
  output logic [31:0] SignExtended_PC,
  output logic        IDEX_RegWrite,
  output logic        IDEX_MemRead,
  output logic        IDEX_MemWrite,
  output logic        IDEX_MemToReg,
  output logic        IDEX_ALUSrc,
  output logic        IDEX_RegDst,
  output logic [1:0]  IDEX_ALUOp,
  output logic [31:0] IDEX_ReadData1,
  output logic [31:0] IDEX_ReadData2,
  output logic [31:0] IDEX_Imm,
  output logic [4:0]  IDEX_Rs,
  output logic [4:0]  IDEX_Rt,
  output logic [4:0]  IDEX_Rd
`ifdef STALL_COUNT_EN
  ,
  output logic [15:0] StallCount
`endif
);

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_dst;
    logic [1:0] alu_op;
  } ctl_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;

  logic [31:0] r_rf [32];
  ctl_t        r_ctl;
  logic [31:0] r_rd1, r_rd2, r_imm;
  logic [4:0]  r_rs, r_rt, r_rd;

  logic [5:0]  w_op;
  logic [4:0]  w_rs, w_rt, w_rd;
  logic [31:0] w_imm, w_rd1, w_rd2;
  ctl_t        w_ctl;
  logic        w_is_beq, w_is_bne, w_is_br;
  logic [4:0]  w_idex_dst;
  logic        w_load_use, w_br_haz, w_stall, w_bubble, w_active;
  logic        w_branch, w_branch_ne, w_zero;

  assign w_op  = IFID_Instruction[31:26];
  assign w_rs  = IFID_Instruction[25:21];
  assign w_rt  = IFID_Instruction[20:16];
  assign w_rd  = IFID_Instruction[15:11];
  assign w_imm = {{16{IFID_Instruction[15]}}, IFID_Instruction[15:0]};

  always_comb begin
    w_ctl    = '0;
    w_is_beq = 1'b0;
    w_is_bne = 1'b0;
    case (w_op)
      OP_R:    begin w_ctl.reg_write = 1'b1; w_ctl.reg_dst = 1'b1; w_ctl.alu_op = 2'b10; end
      OP_LW:   begin
        w_ctl.reg_write  = 1'b1;
        w_ctl.mem_read   = 1'b1;
        w_ctl.mem_to_reg = 1'b1;
        w_ctl.alu_src    = 1'b1;
      end
      OP_SW:   begin w_ctl.mem_write = 1'b1; w_ctl.alu_src = 1'b1; end
      OP_ADDI: begin w_ctl.reg_write = 1'b1; w_ctl.alu_src = 1'b1; end
      OP_BEQ:  begin w_ctl.alu_op = 2'b01; w_is_beq = 1'b1; end
      OP_BNE:  begin w_ctl.alu_op = 2'b01; w_is_bne = 1'b1; end
      default: w_ctl = '0;
    endcase
  end

  assign w_is_br = w_is_beq | w_is_bne;

  // WB bypass lets a same-cycle writeback feed this read without an extra stall.
  always_comb begin
    w_rd1 = '0;
    w_rd2 = '0;
    if (w_rs != 5'd0)
      w_rd1 = (WB_RegWrite && WB_WriteReg == w_rs) ? WB_WriteData : r_rf[w_rs];
    if (w_rt != 5'd0)
      w_rd2 = (WB_RegWrite && WB_WriteReg == w_rt) ? WB_WriteData : r_rf[w_rt];
  end

  // Zero is inverted sense: 0 means the operands compare equal.
  assign w_zero = (w_rd1 != w_rd2);

  assign w_idex_dst = r_ctl.reg_dst ? r_rd : r_rt;

  assign w_load_use = r_ctl.mem_read && (r_rt != 5'd0) && (r_rt == w_rs || r_rt == w_rt);

  // Branches resolve here, so they must wait for any producer still in EX or a load in MEM.
  function automatic logic br_src_hit(input logic [4:0] src);
    br_src_hit = (src != 5'd0) &&
                 ((r_ctl.reg_write && w_idex_dst == src) ||
                  (EXMEM_RegWrite && EXMEM_MemRead && EXMEM_WriteReg == src));
  endfunction

  assign w_br_haz    = w_is_br && (br_src_hit(w_rs) || br_src_hit(w_rt));
  assign w_active    = !reset && !Prop_IFFlush;
  assign w_stall     = w_active && (w_load_use || w_br_haz);
  assign w_bubble    = w_stall || Prop_IFFlush;
  assign w_branch    = w_active && !w_stall && w_is_beq;
  assign w_branch_ne = w_active && !w_stall && w_is_bne;

  assign Zero            = w_zero;
  assign Branch          = w_branch;
  assign BranchNe        = w_branch_ne;
  assign Stall           = w_stall;
  assign IFFlush         = (w_branch && !w_zero) || (w_branch_ne && w_zero);
  assign SignExtended_PC = IFID_PCPlus4 + {w_imm[29:0], 2'b00};

  always_ff @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
    end else if (WB_RegWrite && WB_WriteReg != 5'd0) begin
      r_rf[WB_WriteReg] <= WB_WriteData;
    end
  end

  // A stalled or squashed slot enters EX as a bubble; only the controls matter.
  always_ff @(negedge clk) begin
    if (reset) begin
      r_ctl <= '0;
      r_rd1 <= '0;
      r_rd2 <= '0;
      r_imm <= '0;
      r_rs  <= '0;
      r_rt  <= '0;
      r_rd  <= '0;
    end else begin
      r_ctl <= w_bubble ? ctl_t'('0) : w_ctl;
      r_rd1 <= w_rd1;
      r_rd2 <= w_rd2;
      r_imm <= w_imm;
      r_rs  <= w_rs;
      r_rt  <= w_rt;
      r_rd  <= w_rd;
    end
  end

  assign IDEX_RegWrite  = r_ctl.reg_write;
  assign IDEX_MemRead   = r_ctl.mem_read;
  assign IDEX_MemWrite  = r_ctl.mem_write;
  assign IDEX_MemToReg  = r_ctl.mem_to_reg;
  assign IDEX_ALUSrc    = r_ctl.alu_src;
  assign IDEX_RegDst    = r_ctl.reg_dst;
  assign IDEX_ALUOp     = r_ctl.alu_op;
  assign IDEX_ReadData1 = r_rd1;
  assign IDEX_ReadData2 = r_rd2;
  assign IDEX_Imm       = r_imm;
  assign IDEX_Rs        = r_rs;
  assign IDEX_Rt        = r_rt;
  assign IDEX_Rd        = r_rd;

`ifdef STALL_COUNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(negedge clk) begin
    if (reset)
      r_stall_cnt <= '0;
    else if (w_stall && r_stall_cnt != 16'hFFFF)
      r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign StallCount = r_stall_cnt;
`endif

endmodule

// File: tb/tb_instruction_decode.sv
// Scoreboard bench for instruction_decode: expected ID/EX contents queued at drive time,
// popped after the falling edge that loads them; fetch-facing outputs checked mid-cycle.
module tb_instruction_decode;

  typedef struct packed {
    logic rw, mr, mw, m2r, asrc, rdst;
    logic [1:0] aop;
  } ctl_t;
  typedef struct packed {
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rs, rt, rd;
  } dat_t;
  typedef struct packed {
    ctl_t ctl;
    dat_t dat;
  } idex_t;
  typedef struct {
    ctl_t ctl;
    dat_t dat;
    logic bub;
  } exp_t;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, ADDI = 6'b001000;
  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101;
  localparam logic [31:0] NOP = 32'hFC00_0000;

  logic        clk, reset;
  logic [31:0] IFID_Instruction, IFID_PCPlus4;
  logic        Prop_IFFlush;
  logic        WB_RegWrite;
  logic [4:0]  WB_WriteReg;
  logic [31:0] WB_WriteData;
  logic        EXMEM_RegWrite, EXMEM_MemRead;
  logic [4:0]  EXMEM_WriteReg;
  logic        Zero, Branch, BranchNe, IFFlush, Stall;
  logic [31:0] SignExtended_PC;
  logic        IDEX_RegWrite, IDEX_MemRead, IDEX_MemWrite, IDEX_MemToReg, IDEX_ALUSrc, IDEX_RegDst;
  logic [1:0]  IDEX_ALUOp;
  logic [31:0] IDEX_ReadData1, IDEX_ReadData2, IDEX_Imm;
  logic [4:0]  IDEX_Rs, IDEX_Rt, IDEX_Rd;
`ifdef STALL_COUNT_EN
  logic [15:0] StallCount;
`endif

  int checks = 0;
  int failures = 0;
  logic [31:0] m_rf [32];
  exp_t sb[$];

  instruction_decode dut (
    .clk(clk), .reset(reset),
    .IFID_Instruction(IFID_Instruction), .IFID_PCPlus4(IFID_PCPlus4),
    .Prop_IFFlush(Prop_IFFlush),
    .WB_RegWrite(WB_RegWrite), .WB_WriteReg(WB_WriteReg), .WB_WriteData(WB_WriteData),
    .EXMEM_RegWrite(EXMEM_RegWrite), .EXMEM_MemRead(EXMEM_MemRead), .EXMEM_WriteReg(EXMEM_WriteReg),
    .Zero(Zero), .Branch(Branch), .BranchNe(BranchNe), .IFFlush(IFFlush), .Stall(Stall),
    .SignExtended_PC(SignExtended_PC),
    .IDEX_RegWrite(IDEX_RegWrite), .IDEX_MemRead(IDEX_MemRead), .IDEX_MemWrite(IDEX_MemWrite),
    .IDEX_MemToReg(IDEX_MemToReg), .IDEX_ALUSrc(IDEX_ALUSrc), .IDEX_RegDst(IDEX_RegDst),
    .IDEX_ALUOp(IDEX_ALUOp),
    .IDEX_ReadData1(IDEX_ReadData1), .IDEX_ReadData2(IDEX_ReadData2), .IDEX_Imm(IDEX_Imm),
    .IDEX_Rs(IDEX_Rs), .IDEX_Rt(IDEX_Rt), .IDEX_Rd(IDEX_Rd)
`ifdef STALL_COUNT_EN
    , .StallCount(StallCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd);
    rtype = {6'b000000, rs, rt, rd, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    itype = {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rdval(input logic [4:0] r);
    if (r == 5'd0) rdval = '0;
    else if (WB_RegWrite && WB_WriteReg == r) rdval = WB_WriteData;
    else rdval = m_rf[r];
  endfunction

  function automatic exp_t mk_exp(input logic [31:0] ins, input logic bub);
    exp_t e;
    e.bub = bub;
    e.ctl = '0;
    if (!bub)
      case (ins[31:26])
        6'b000000: begin e.ctl.rw = 1; e.ctl.rdst = 1; e.ctl.aop = 2'b10; end
        LW:        begin e.ctl.rw = 1; e.ctl.mr = 1; e.ctl.m2r = 1; e.ctl.asrc = 1; end
        SW:        begin e.ctl.mw = 1; e.ctl.asrc = 1; end
        ADDI:      begin e.ctl.rw = 1; e.ctl.asrc = 1; end
        BEQ, BNE:  e.ctl.aop = 2'b01;
        default:   e.ctl = '0;
      endcase
    e.dat.rd1 = rdval(ins[25:21]);
    e.dat.rd2 = rdval(ins[20:16]);
    e.dat.imm = {{16{ins[15]}}, ins[15:0]};
    e.dat.rs  = ins[25:21];
    e.dat.rt  = ins[20:16];
    e.dat.rd  = ins[15:11];
    return e;
  endfunction

  function automatic idex_t get_idex();
    idex_t g;
    g.ctl = {IDEX_RegWrite, IDEX_MemRead, IDEX_MemWrite, IDEX_MemToReg, IDEX_ALUSrc,
             IDEX_RegDst, IDEX_ALUOp};
    g.dat = {IDEX_ReadData1, IDEX_ReadData2, IDEX_Imm, IDEX_Rs, IDEX_Rt, IDEX_Rd};
    return g;
  endfunction

  // {Zero, Branch, BranchNe, IFFlush, Stall}
  function automatic logic [4:0] get_fe();
    return {Zero, Branch, BranchNe, IFFlush, Stall};
  endfunction

  task automatic tick();
    logic rs_, wr;
    logic [4:0] wa;
    logic [31:0] wd;
    rs_ = reset; wr = WB_RegWrite; wa = WB_WriteReg; wd = WB_WriteData;
    @(negedge clk);
    if (rs_) for (int i = 0; i < 32; i++) m_rf[i] = '0;
    else if (wr && wa != 5'd0) m_rf[wa] = wd;
    #1;
  endtask

  task automatic idle();
    reset = 0; IFID_Instruction = NOP; IFID_PCPlus4 = 32'h0; Prop_IFFlush = 0;
    WB_RegWrite = 0; WB_WriteReg = 0; WB_WriteData = 0;
    EXMEM_RegWrite = 0; EXMEM_MemRead = 0; EXMEM_WriteReg = 0;
  endtask

  task automatic wr_reg(input logic [4:0] r, input logic [31:0] v);
    IFID_Instruction = NOP;
    WB_RegWrite = 1; WB_WriteReg = r; WB_WriteData = v;
    tick();
    WB_RegWrite = 0;
  endtask

  task automatic test_reset();
    idex_t g;
    exp_t e;
    idle();
    reset = 1;
    IFID_Instruction = itype(BEQ, 5'd1, 5'd1, 16'd0);
    EXMEM_RegWrite = 1; EXMEM_MemRead = 1; EXMEM_WriteReg = 5'd1;
    #1;
    checks++;
    if (get_fe() & 5'b01111) begin
      failures++; $display("FAIL reset_fe0 got=%b exp=x0000", get_fe());
    end
    tick();
    WB_RegWrite = 1; WB_WriteReg = 5'd5; WB_WriteData = 32'hDEAD_BEEF;
    tick();
    g = get_idex();
    checks++;
    if (g !== '0) begin failures++; $display("FAIL reset_idex got=%h exp=0", g); end
    checks++;
    if (get_fe() & 5'b01111) begin
      failures++; $display("FAIL reset_fe1 got=%b exp=x0000", get_fe());
    end
    reset = 0; WB_RegWrite = 0; EXMEM_RegWrite = 0; EXMEM_MemRead = 0;
    IFID_Instruction = rtype(5'd5, 5'd0, 5'd4);
    #1;
    checks++;
    if (get_fe() !== 5'b00000) begin
      failures++; $display("FAIL reset_fe2 got=%b exp=00000", get_fe());
    end
    sb.push_back(mk_exp(IFID_Instruction, 0));
    tick();
    e = sb.pop_front(); g = get_idex(); checks++;
    if (g.ctl !== e.ctl || (!e.bub && g.dat !== e.dat)) begin
      failures++; $display("FAIL reset_read5 ctl=%h/%h dat=%h/%h", g.ctl, e.ctl, g.dat, e.dat);
    end
  endtask

  task automatic test_bypass();
    idex_t g;
    exp_t e;
    IFID_Instruction = rtype(5'd3, 5'd0, 5'd4);
    WB_RegWrite = 1; WB_WriteReg = 5'd3; WB_WriteData = 32'h0000_1234;
    sb.push_back(mk_exp(IFID_Instruction, 0));
    tick();
    e = sb.pop_front(); g = get_idex(); checks++;
    if (g.ctl !== e.ctl || (!e.bub && g.dat !== e.dat)) begin
      failures++; $display("FAIL bypass_r3 ctl=%h/%h dat=%h/%h", g.ctl, e.ctl, g.dat, e.dat);
    end
    IFID_Instruction = rtype(5'd0, 5'd3, 5'd4);
    WB_WriteReg = 5'd0; WB_WriteData = 32'hBEEF_0000;
    sb.push_back(mk_exp(IFID_Instruction, 0));
    tick();
    e = sb.pop_front(); g = get_idex(); checks++;
    if (g.ctl !== e.ctl || (!e.bub && g.dat !== e.dat)) begin
      failures++; $display("FAIL bypass_r0 ctl=%h/%h dat=%h/%h", g.ctl, e.ctl, g.dat, e.dat);
    end
    WB_RegWrite = 0;
  endtask

  task automatic test_beq();
    idex_t g;
    exp_t e;
    wr_reg(5'd1, 32'd7);
    wr_reg(5'd2, 32'd7);
    IFID_Instruction = itype(BEQ, 5'd1, 5'd2, 16'd3); IFID_PCPlus4 = 32'h40;
    #1;
    checks++;
    if (get_fe() !== 5'b01010) begin
      failures++; $display("FAIL beq_taken_fe got=%b exp=01010", get_fe());
    end
    checks++;
    if (SignExtended_PC !== 32'h4C) begin
      failures++; $display("FAIL beq_taken_pc got=%h exp=0000004c", SignExtended_PC);
    end
    sb.push_back(mk_exp(IFID_Instruction, 0));
    tick();
    e = sb.pop_front(); g = get_idex(); checks++;
    if (g.ctl !== e.ctl || (!e.bub && g.dat !== e.dat)) begin
      failures++; $display("FAIL beq_idex ctl=%h/%h dat=%h/%h", g.ctl, e.ctl, g.dat, e.dat);
    end
    wr_reg(5'd3, 32'd9);
    IFID_Instruction = itype(BEQ, 5'd1, 5'd3, 16'd2); IFID_PCPlus4 = 32'hFFFF_FFFC;
    #1;
    checks++;
    if (get_fe() !== 5'b11000) begin
      failures++; $display("FAIL beq_nt_fe got=%b exp=11000", get_fe());
    end
    checks++;
    if (SignExtended_PC !== 32'h4) begin
      failures++; $display("FAIL beq_wrap_pc got=%h exp=00000004", SignExtended_PC);
    end
  endtask

  task automatic test_bne();
    idex_t g;
    exp_t e;
    IFID_Instruction = itype(BNE, 5'd1, 5'd2, 16'hFFFF); IFID_PCPlus4 = 32'h100;
    #1;
    checks++;
    if (get_fe() !== 5'b00100) begin
      failures++; $display("FAIL bne_nt_fe got=%b exp=00100", get_fe());
    end
    checks++;
    if (SignExtended_PC !== 32'hFC) begin
      failures++; $display("FAIL bne_pc got=%h exp=000000fc", SignExtended_PC);
    end
    sb.push_back(mk_exp(IFID_Instruction, 0));
    tick();
    e = sb.pop_front(); g = get_idex(); checks++;
    if (g.ctl !== e.ctl || (!e.bub && g.dat !== e.dat)) begin
      failures++; $display("FAIL bne_idex ctl=%h/%h dat=%h/%h", g.ctl, e.ctl, g.dat, e.dat);
    end
    IFID_Instruction = itype(BNE, 5'd1, 5'd3, 16'd1);
    #1;
    checks++;
    if (get_fe() !== 5'b10110) begin
      failures++; $display("FAIL bne_taken_fe got=%b exp=10110", get_fe());
    end
    tick();
  endtask

  task automatic test_squash();
    idex_t g;
    exp_t e;
    Prop_IFFlush = 1;
    IFID_Instruction = itype(BEQ, 5'd1, 5'd2, 16'd3);
    EXMEM_RegWrite = 1; EXMEM_MemRead = 1; EXMEM_WriteReg = 5'd1;
    #1;
    checks++;
    if (get_fe() !== 5'b00000) begin
      failures++; $display("FAIL squash_fe got=%b exp=00000", get_fe());
    end
    sb.push_back(mk_exp(IFID_Instruction, 1));
    tick();
    e = sb.pop_front(); g = get_idex(); checks++;
    if (g.ctl !== e.ctl || (!e.bub && g.dat !== e.dat)) begin
      failures++; $display("FAIL squash_idex ctl=%h/%h dat=%h/%h", g.ctl, e.ctl, g.dat, e.dat);
    end
    Prop_IFFlush = 0; EXMEM_RegWrite = 0; EXMEM_MemRead = 0; EXMEM_WriteReg = 0;
  endtask

  task automatic test_load_use();
    idex_t g;
    exp_t e;
    IFID_Instruction = itype(LW, 5'd0, 5'd5, 16'd0);
    #1;
    checks++;
    if (Stall !== 1'b0) begin failures++; $display("FAIL lu_lw_stall got=%b exp=0", Stall); end
    sb.push_back(mk_exp(IFID_Instruction, 0));
    tick();
    e = sb.pop_front(); g = get_idex(); checks++;
    if (g.ctl !== e.ctl || (!e.bub && g.dat !== e.dat)) begin
      failures++; $display("FAIL lu_lw_idex ctl=%h/%h dat=%h/%h", g.ctl, e.ctl, g.dat, e.dat);
    end
    IFID_Instruction = rtype(5'd5, 5'd5, 5'd6);
    #1;
    checks++;
    if (get_fe() !== 5'b00001) begin
      failures++; $display("FAIL lu_stall1 got=%b exp=00001", get_fe());
    end
    sb.push_back(mk_exp(IFID_Instruction, 1));
    tick();
    e = sb.pop_front(); g = get_idex(); checks++;
    if (g.ctl !== e.ctl || (!e.bub && g.dat !== e.dat)) begin
      failures++; $display("FAIL lu_bubble ctl=%h/%h dat=%h/%h", g.ctl, e.ctl, g.dat, e.dat);
    end
    EXMEM_RegWrite = 1; EXMEM_MemRead = 1; EXMEM_WriteReg = 5'd5;
    #1;
    checks++;
    if (get_fe() !== 5'b00000) begin
      failures++; $display("FAIL lu_stall2 got=%b exp=00000", get_fe());
    end
    sb.push_back(mk_exp(IFID_Instruction, 0));
    tick();
    e = sb.pop_front(); g = get_idex(); checks++;
    if (g.ctl !== e.ctl || (!e.bub && g.dat !== e.dat)) begin
      failures++; $display("FAIL lu_add ctl=%h/%h dat=%h/%h", g.ctl, e.ctl, g.dat, e.dat);
    end
    EXMEM_RegWrite = 0; EXMEM_MemRead = 0; EXMEM_WriteReg = 0;
  endtask

  task automatic test_back_to_back();
    idex_t g;
    exp_t e;
    logic [5:0] ops [5];
    ops[0] = 6'b000000; ops[1] = ADDI; ops[2] = SW; ops[3] = 6'h3F; ops[4] = 6'h02;
    for (int n = 0; n < 24; n++) begin
      IFID_Instruction = {ops[$urandom_range(0, 4)], 26'($urandom)};
      WB_RegWrite  = 1'($urandom);
      WB_WriteReg  = 5'($urandom);
      WB_WriteData = $urandom;
      sb.push_back(mk_exp(IFID_Instruction, 0));
      tick();
      e = sb.pop_front(); g = get_idex(); checks++;
      if (g.ctl !== e.ctl || (!e.bub && g.dat !== e.dat)) begin
        failures++;
        $display("FAIL b2b_%0d ins=%h ctl=%h/%h dat=%h/%h", n, IFID_Instruction, g.ctl, e.ctl,
                 g.dat, e.dat);
      end
    end
    WB_RegWrite = 0;
  endtask

  task automatic test_lw_branch();
    idex_t g;
    exp_t e;
    idle();
    reset = 1;
    tick();
    reset = 0;
`ifdef STALL_COUNT_EN
    checks++;
    if (StallCount !== 16'd0) begin failures++; $display("FAIL cnt_start got=%0d exp=0", StallCount); end
`endif
    IFID_Instruction = itype(LW, 5'd0, 5'd7, 16'd0);
    sb.push_back(mk_exp(IFID_Instruction, 0));
    tick();
    e = sb.pop_front(); g = get_idex(); checks++;
    if (g.ctl !== e.ctl || (!e.bub && g.dat !== e.dat)) begin
      failures++; $display("FAIL lwbr_lw ctl=%h/%h dat=%h/%h", g.ctl, e.ctl, g.dat, e.dat);
    end
    IFID_Instruction = itype(BEQ, 5'd7, 5'd0, 16'd1); IFID_PCPlus4 = 32'h200;
    #1;
    checks++;
    if (get_fe() !== 5'b00001) begin
      failures++; $display("FAIL lwbr_stall_idex got=%b exp=00001", get_fe());
    end
    sb.push_back(mk_exp(IFID_Instruction, 1));
    tick();
    e = sb.pop_front(); g = get_idex(); checks++;
    if (g.ctl !== e.ctl) begin
      failures++; $display("FAIL lwbr_bubble1 ctl=%h/%h", g.ctl, e.ctl);
    end
    EXMEM_RegWrite = 1; EXMEM_MemRead = 1; EXMEM_WriteReg = 5'd7;
    #1;
    checks++;
    if (get_fe() !== 5'b00001) begin
      failures++; $display("FAIL lwbr_stall_exmem got=%b exp=00001", get_fe());
    end
    sb.push_back(mk_exp(IFID_Instruction, 1));
    tick();
    e = sb.pop_front(); g = get_idex(); checks++;
    if (g.ctl !== e.ctl) begin
      failures++; $display("FAIL lwbr_bubble2 ctl=%h/%h", g.ctl, e.ctl);
    end
    EXMEM_RegWrite = 0; EXMEM_MemRead = 0; EXMEM_WriteReg = 0;
    WB_RegWrite = 1; WB_WriteReg = 5'd7; WB_WriteData = 32'd5;
    #1;
    checks++;
    if (get_fe() !== 5'b11000) begin
      failures++; $display("FAIL lwbr_resolve got=%b exp=11000", get_fe());
    end
`ifdef STALL_COUNT_EN
    checks++;
    if (StallCount !== 16'd2) begin failures++; $display("FAIL cnt_two got=%0d exp=2", StallCount); end
`endif
    sb.push_back(mk_exp(IFID_Instruction, 0));
    tick();
    e = sb.pop_front(); g = get_idex(); checks++;
    if (g.ctl !== e.ctl || (!e.bub && g.dat !== e.dat)) begin
      failures++; $display("FAIL lwbr_beq ctl=%h/%h dat=%h/%h", g.ctl, e.ctl, g.dat, e.dat);
    end
`ifdef STALL_COUNT_EN
    checks++;
    if (StallCount !== 16'd2) begin failures++; $display("FAIL cnt_hold got=%0d exp=2", StallCount); end
`endif
    WB_RegWrite = 0;
  endtask

  initial begin
    idle();
    test_reset();
    test_bypass();
    test_beq();
    test_bne();
    test_squash();
    test_load_use();
    test_back_to_back();
    test_lw_branch();
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL sb_drain left=%0d exp=0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_decode.md
INSTRUCTION_DECODE -- requirements
Module: instruction_decode

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on falling edge of clk, matching the fetch stage.
REQ-002 SHALL have port reset  input  1  synchronous, active-high; sampled on falling edge of clk.
REQ-003 SHALL have ports IFID_Instruction  input  32 and IFID_PCPlus4  input  32, both from the fetch-stage IF/ID register.
REQ-004 SHALL have port Prop_IFFlush  input  1  high when IF/ID holds a squashed slot.
REQ-005 SHALL have ports WB_RegWrite  input  1, WB_WriteReg  input  5 and WB_WriteData  input  32, forming the register-file write port.
REQ-006 SHALL have ports EXMEM_RegWrite  input  1, EXMEM_MemRead  input  1 and EXMEM_WriteReg  input  5, carrying MEM-stage hazard information.
REQ-007 SHALL have ports Zero  output  1, Branch  output  1, BranchNe  output  1, IFFlush  output  1, Stall  output  1 and SignExtended_PC  output  32, all driven to the fetch stage.
REQ-008 SHALL have these ID/EX register outputs: IDEX_RegWrite, IDEX_MemRead, IDEX_MemWrite, IDEX_MemToReg, IDEX_ALUSrc and IDEX_RegDst (1 bit each); IDEX_ALUOp (2); IDEX_ReadData1, IDEX_ReadData2 and IDEX_Imm (32 each); IDEX_Rs, IDEX_Rt and IDEX_Rd (5 each).

Function
REQ-009 SHALL decode opcodes as follows; every other opcode SHALL decode as a NOP with all controls 0.
- 000000 R-type: RegWrite, RegDst, ALUOp=10.
- 100011 lw: RegWrite, MemRead, MemToReg, ALUSrc, ALUOp=00.
- 101011 sw: MemWrite, ALUSrc, ALUOp=00.
- 001000 addi: RegWrite, ALUSrc, ALUOp=00.
- 000100 beq / 000101 bne: ALUOp=01, no writes.
REQ-010 SHALL contain a 32x32 register file.
- $0 reads 0 and writes to it are ignored.
- Write occurs on falling edge when WB_RegWrite=1.
REQ-011 SHALL read the register file combinationally with WB bypass: when WB_RegWrite=1, WB_WriteReg=source register and source register !=0, the read returns WB_WriteData.
REQ-012 SHALL compute SignExtended_PC = IFID_PCPlus4 + (sign-extended imm16 << 2), modulo 2^32.
REQ-013 SHALL drive Zero = 0 when the rs and rt read values are equal, and 1 otherwise.
REQ-014 SHALL assert Branch for beq and BranchNe for bne only when Prop_IFFlush=0 and Stall=0.
REQ-015 SHALL assert IFFlush=1 exactly when a beq is taken (Branch=1, Zero=0) or a bne is taken (BranchNe=1, Zero=1).
REQ-016 SHALL assert Stall (load-use) when IDEX_MemRead=1 and IDEX_Rt !=0 matches the IFID rs or rt.
REQ-017 SHALL assert Stall (branch hazard) when a beq/bne source register !=0 matches any of:
- IDEX destination with IDEX_RegWrite=1 (Rd if RegDst=1, else Rt);
- EXMEM_WriteReg with EXMEM_RegWrite=1 and EXMEM_MemRead=1.
REQ-018 SHALL behave as follows on a falling edge with Stall=1 or Prop_IFFlush=1:
- load a bubble into ID/EX: all IDEX control bits 0;
- data fields SHALL be don't-care.
REQ-019 SHALL load ID/EX from the decoded IF/ID contents on every other falling edge, giving one-cycle latency.
REQ-020 SHALL evaluate a lw-then-dependent-beq sequence as follows:
- stall 2 cycles;
- the first stall cycle comes from REQ-016/017 (IDEX), the second from REQ-017 (EXMEM).
REQ-021 SHALL NOT assert Stall or any branch output for a squashed slot (Prop_IFFlush=1).

Reset
REQ-022 SHALL, on falling edge with reset=1, clear all ID/EX outputs and all 32 registers to 0.
REQ-023 SHALL give reset priority over register-file writes and ID/EX loads in the same cycle.
REQ-024 SHALL keep Branch, BranchNe, IFFlush and Stall at 0 while reset=1.

Configuration
REQ-025 SHALL, when macro STALL_COUNT_EN is defined, add output StallCount (16):
- increments on each falling edge with Stall=1;
- saturates at 0xFFFF;
- is cleared by reset.
REQ-026 SHALL, when STALL_COUNT_EN is undefined, omit the StallCount port and counter, with all other behaviour identical.

Verification
REQ-027 SHALL verify reset: reset=1 for 2 cycles -> all IDEX outputs 0, Stall=0, and reading $5 returns 0.
REQ-028 SHALL verify WB bypass: WB writes $3=0x1234 in the same cycle IFID holds "add $4,$3,$0" -> IDEX_ReadData1=0x1234 after the next edge.
REQ-029 SHALL verify beq taken:
- setup: $1=$2=7, IFID holds "beq $1,$2,+3", IFID_PCPlus4=0x40;
- response: Zero=0, Branch=1, IFFlush=1, SignExtended_PC=0x4C.
REQ-030 SHALL verify bne not taken: $1=7, $2=7, "bne $1,$2,-1" -> BranchNe=1, Zero=0, IFFlush=0, and SignExtended_PC = PCPlus4-4.
REQ-031 SHALL verify the load-use stall: "lw $5,0($0)" followed by "add $6,$5,$5" -> Stall=1 for exactly one cycle, then a bubble in ID/EX, then the add.
REQ-032 SHALL verify the stall counter with STALL_COUNT_EN defined: lw followed by dependent beq -> Stall high for 2 cycles and StallCount increments 0->2.
